// File: rtl/laser_pkg.sv
// Shared state encoding and byte constants for the laser transmit scheduler.
// Defining LASER_TX_CHECKSUM_EN adds the CSUM state that closes each packet.
package laser_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] PAD_BYTE  = 8'h00;
  localparam int         LANES     = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    FILL1 = 3'd2,
    FILL2 = 3'd3,
    SEND  = 3'd4
`ifdef LASER_TX_CHECKSUM_EN
    , CSUM = 3'd5
`endif
  } state_t;

  // States in which a lane pair is offered to the transmitter.
  function automatic logic is_presenting(input state_t s);
    logic p;
    p = (s == SYNC) || (s == SEND);
`ifdef LASER_TX_CHECKSUM_EN
    p = p || (s == CSUM);
`endif
    return p;
  endfunction

endpackage

// File: rtl/laser_tx_scheduler_if.sv
// Host byte stream and dual-lane transmitter handshake of the scheduler.
// master = scheduler side, slave = host/transmitter side.
interface laser_tx_scheduler_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data1;
  logic [7:0] tx_data2;
  logic       tx_ready1;
  logic       tx_ready2;
  logic       tx_done;

  modport master (
    input  in_data, in_valid, tx_done,
    output in_ready, tx_data1, tx_data2, tx_ready1, tx_ready2
  );

  modport slave (
    output in_data, in_valid, tx_done,
    input  in_ready, tx_data1, tx_data2, tx_ready1, tx_ready2
  );
endinterface

// File: rtl/laser_idle_timer.sv
// Counts cycles spent waiting for a host byte; expired flags the TIMEOUT-th
// consecutive idle cycle so the scheduler can pad instead of stalling.
module laser_idle_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count_reg;
  logic [15:0] count_next;

  assign expired = run && (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    if (restart) begin
      count_next = '0;
    end else if (run && !expired) begin
      count_next = count_reg + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/laser_tx_scheduler.sv
// Packs host bytes into sync + PKT_PAIRS payload pairs for two laser lanes,
// padding on host timeout. LASER_TX_CHECKSUM_EN appends an XOR checksum pair.
module laser_tx_scheduler
  import laser_pkg::*;
#(
  parameter int PKT_PAIRS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  laser_tx_scheduler_if.master link,
  output logic                 busy,
  output logic                 pkt_done,
  output logic [15:0]          pkt_count
);

  localparam logic [8:0] PAIRS_LAST = 9'(PKT_PAIRS);

  state_t      state_reg, state_next;
  logic [7:0]  pair_cnt_reg, pair_cnt_next;
  logic        tx_ready_reg, tx_ready_next;
  logic        pkt_done_reg, pkt_done_next;
  logic [15:0] pkt_count_reg;

  logic        fill_state;
  logic        accept;
  logic        pair_done;
  logic        last_pair;
  logic        timed_out;
  logic        timer_restart;
  logic        tx_load;

  logic [LANES-1:0]      lane_we;
  logic [LANES-1:0][7:0] lane_load;
  logic [LANES-1:0][7:0] present_data;
  logic [LANES-1:0][7:0] tx_lane;
`ifdef LASER_TX_CHECKSUM_EN
  logic                  csum_clear;
`endif

  assign fill_state = (state_reg == FILL1) || (state_reg == FILL2);
  assign accept     = link.in_valid && fill_state;
  // A done pulse only counts once the pair has actually been offered.
  assign pair_done  = link.tx_done && tx_ready_reg;
  assign last_pair  = ({1'b0, pair_cnt_reg} + 9'd1) >= PAIRS_LAST;

  laser_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (timer_restart),
    .run     (fill_state),
    .expired (timed_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pair_cnt_reg  <= '0;
      tx_ready_reg  <= 1'b0;
      pkt_done_reg  <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pair_cnt_reg  <= pair_cnt_next;
      tx_ready_reg  <= tx_ready_next;
      pkt_done_reg  <= pkt_done_next;
      if (pkt_done_next) begin
        pkt_count_reg <= pkt_count_reg + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (en && link.in_valid) state_next = SYNC;
      SYNC:  if (pair_done) state_next = FILL1;
      FILL1: begin
        if (accept) begin
          state_next = FILL2;
        end else if (timed_out) begin
          state_next = SEND;
        end
      end
      FILL2: if (accept || timed_out) state_next = SEND;
      SEND: begin
        if (pair_done) begin
`ifdef LASER_TX_CHECKSUM_EN
          state_next = last_pair ? CSUM : FILL1;
`else
          state_next = last_pair ? IDLE : FILL1;
`endif
        end
      end
`ifdef LASER_TX_CHECKSUM_EN
      CSUM:  if (pair_done) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lane_we       = '0;
    lane_load     = '0;
    pair_cnt_next = pair_cnt_reg;
    tx_ready_next = is_presenting(state_reg) && !pair_done;
    tx_load       = is_presenting(state_reg) && !tx_ready_reg;
    pkt_done_next = (state_reg != IDLE) && (state_next == IDLE);
    timer_restart = accept ||
                    ((state_next != state_reg) &&
                     ((state_next == FILL1) || (state_next == FILL2)));
`ifdef LASER_TX_CHECKSUM_EN
    csum_clear    = 1'b0;
`endif
    case (state_reg)
      SYNC: begin
        if (pair_done) begin
          pair_cnt_next = '0;
`ifdef LASER_TX_CHECKSUM_EN
          csum_clear    = 1'b1;
`endif
        end
      end
      FILL1: begin
        if (accept) begin
          lane_we[0]   = 1'b1;
          lane_load[0] = link.in_data;
        end else if (timed_out) begin
          lane_we      = '1;
          lane_load[0] = PAD_BYTE;
          lane_load[1] = PAD_BYTE;
        end
      end
      FILL2: begin
        if (accept) begin
          lane_we[1]   = 1'b1;
          lane_load[1] = link.in_data;
        end else if (timed_out) begin
          lane_we[1]   = 1'b1;
          lane_load[1] = PAD_BYTE;
        end
      end
      SEND: if (pair_done) pair_cnt_next = pair_cnt_reg + 8'd1;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] data_reg;
    logic [7:0] tx_reg;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_reg <= '0;
      end else if (lane_we[gi]) begin
        data_reg <= lane_load[gi];
      end
    end

`ifdef LASER_TX_CHECKSUM_EN
    logic [7:0] csum_reg;

    // Pads are folded in as well, so the checksum covers every payload byte sent.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        csum_reg <= '0;
      end else if (csum_clear) begin
        csum_reg <= '0;
      end else if (lane_we[gi]) begin
        csum_reg <= csum_reg ^ lane_load[gi];
      end
    end

    assign present_data[gi] = (state_reg == SYNC) ? SYNC_BYTE :
                              (state_reg == CSUM) ? csum_reg  : data_reg;
`else
    assign present_data[gi] = (state_reg == SYNC) ? SYNC_BYTE : data_reg;
`endif

    // Captured once as tx_ready rises, then frozen until the pair is done.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        tx_reg <= '0;
      end else if (tx_load) begin
        tx_reg <= present_data[gi];
      end
    end

    assign tx_lane[gi] = tx_reg;
  end

  assign link.in_ready  = fill_state;
  assign link.tx_data1  = tx_lane[0];
  assign link.tx_data2  = tx_lane[1];
  assign link.tx_ready1 = tx_ready_reg;
  assign link.tx_ready2 = tx_ready_reg;
  assign busy           = (state_reg != IDLE);
  assign pkt_done       = pkt_done_reg;
  assign pkt_count      = pkt_count_reg;

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Directed bench for laser_tx_scheduler (PKT_PAIRS=2, TIMEOUT=8) with a pair
// scoreboard fed by the stimulus and drained by a transmitter model.
module tb_laser_tx_scheduler;

  logic        clock;
  logic        reset_n;
  logic        en;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_count;
  logic        tx_done_model;
  logic        tx_done_force;

  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  int          rst_epoch = 0;
  logic [15:0] exp_q[$];

  laser_tx_scheduler_if link();

  assign link.tx_done = tx_done_model | tx_done_force;

  laser_tx_scheduler #(
    .PKT_PAIRS (2),
    .TIMEOUT   (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .link      (link),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_count (pkt_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (link.in_ready !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_wait", {15'd0, link.in_ready}, 16'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    link.in_data  = b;
    link.in_valid = 1'b1;
    wait_in_ready();
    @(negedge clock);
    link.in_valid = 1'b0;
    $display("host byte %h accepted", b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("idle_reached", {15'd0, busy}, 16'd0);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string phase);
    chk({phase, "_in_ready"},  {15'd0, link.in_ready},  16'd0);
    chk({phase, "_tx_ready1"}, {15'd0, link.tx_ready1}, 16'd0);
    chk({phase, "_tx_ready2"}, {15'd0, link.tx_ready2}, 16'd0);
    chk({phase, "_tx_data1"},  {8'd0, link.tx_data1},   16'd0);
    chk({phase, "_tx_data2"},  {8'd0, link.tx_data2},   16'd0);
    chk({phase, "_busy"},      {15'd0, busy},           16'd0);
    chk({phase, "_pkt_done"},  {15'd0, pkt_done},       16'd0);
    chk({phase, "_pkt_count"}, pkt_count,               16'd0);
  endtask

  // Transmitter: finishes each offered pair 3 cycles after tx_ready rises.
  initial begin : tx_model
    logic [15:0] pair;
    logic [15:0] want;
    int          epoch;
    tx_done_model = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && link.tx_ready1 === 1'b1) begin
        epoch = rst_epoch;
        pair  = {link.tx_data1, link.tx_data2};
        chk("tx_ready2_pair", {15'd0, link.tx_ready2}, 16'd1);
        chk("sb_has_entry", {15'd0, exp_q.size() != 0}, 16'd1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk("tx_pair", pair, want);
          $display("tx pair (%h,%h) expected (%h,%h)", pair[15:8], pair[7:0], want[15:8], want[7:0]);
        end
        repeat (2) @(negedge clock);
        if (epoch == rst_epoch) begin
          chk("tx_data_hold", {link.tx_data1, link.tx_data2}, pair);
          chk("tx_ready_hold", {15'd0, link.tx_ready1}, 16'd1);
          tx_done_model = 1'b1;
          @(negedge clock);
          tx_done_model = 1'b0;
        end
      end
    end
  end

  initial begin : pulse_mon
    forever begin
      @(negedge clock);
      if (pkt_done === 1'b1) pulses++;
    end
  end

  initial begin : stim
    int base;
    reset_n       = 1'b0;
    en            = 1'b0;
    link.in_valid = 1'b0;
    link.in_data  = 8'h00;
    tx_done_force = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Full packet from host bytes.
    en = 1'b1;
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
`ifdef LASER_TX_CHECKSUM_EN
    exp_q.push_back(16'h444C);
`endif
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    wait_idle();
    chk("pkt1_pulses", 16'(pulses), 16'd1);
    chk("pkt1_count", pkt_count, 16'd1);

    // Host starves after one byte: both timeouts pad.
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h1200);
    exp_q.push_back(16'h0000);
`ifdef LASER_TX_CHECKSUM_EN
    exp_q.push_back(16'h1200);
`endif
    send_byte(8'h12);
    wait_idle();
    chk("pkt2_pulses", 16'(pulses), 16'd2);
    chk("pkt2_count", pkt_count, 16'd2);

    // Disabled: valid data must not start a packet.
    en            = 1'b0;
    link.in_data  = 8'h99;
    link.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("dis_in_ready", {15'd0, link.in_ready}, 16'd0);
      chk("dis_busy", {15'd0, busy}, 16'd0);
    end
    link.in_valid = 1'b0;
    @(negedge clock);

    // en dropped after the sync pair: packet still completes.
    en = 1'b1;
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h2143);
    exp_q.push_back(16'h6587);
`ifdef LASER_TX_CHECKSUM_EN
    exp_q.push_back(16'h44C4);
`endif
    link.in_data  = 8'h21;
    link.in_valid = 1'b1;
    wait_in_ready();
    en = 1'b0;
    @(negedge clock);
    link.in_valid = 1'b0;
    send_byte(8'h43);
    send_byte(8'h65);
    send_byte(8'h87);
    wait_idle();
    chk("pkt3_pulses", 16'(pulses), 16'd3);
    chk("pkt3_count", pkt_count, 16'd3);

    // Next packet waits for en.
    link.in_data  = 8'h5A;
    link.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("en_gate_busy", {15'd0, busy}, 16'd0);
    end
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h5AC3);
    exp_q.push_back(16'h3C00);
`ifdef LASER_TX_CHECKSUM_EN
    exp_q.push_back(16'h66C3);
`endif
    en = 1'b1;
    begin
      int n = 0;
      while (busy !== 1'b1 && n < 50) begin
        @(negedge clock);
        n++;
      end
      chk("start_busy", {15'd0, busy}, 16'd1);
    end
    link.in_valid = 1'b0;
    wait_in_ready();
    tx_done_force = 1'b1;
    @(negedge clock);
    tx_done_force = 1'b0;
    chk("fill1_done_ignored", {15'd0, link.in_ready}, 16'd1);
    chk("fill1_no_tx_ready", {15'd0, link.tx_ready1}, 16'd0);
    send_byte(8'h5A);
    link.in_data  = 8'hC3;
    link.in_valid = 1'b1;
    wait_in_ready();
    @(negedge clock);
    link.in_data = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      chk("send_in_ready", {15'd0, link.in_ready}, 16'd0);
      @(negedge clock);
    end
    wait_in_ready();
    @(negedge clock);
    link.in_valid = 1'b0;
    wait_idle();
    chk("pkt4_pulses", 16'(pulses), 16'd4);
    chk("pkt4_count", pkt_count, 16'd4);

    // Reset while a payload pair is on the lanes.
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h1122);
    send_byte(8'h11);
    send_byte(8'h22);
    begin
      int n = 0;
      while (link.tx_ready1 !== 1'b1 && n < 50) begin
        @(negedge clock);
        n++;
      end
      chk("send_tx_ready", {15'd0, link.tx_ready1}, 16'd1);
    end
    base = pulses;
    #2;
    reset_n = 1'b0;
    rst_epoch++;
    #1;
    check_all_zero("async_rst");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_no_pulse", 16'(pulses), 16'(base));
    chk("rst_idle_busy", {15'd0, busy}, 16'd0);
    chk("rst_sb_drained", 16'(exp_q.size()), 16'd0);

    // Clean restart after reset.
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h7788);
    exp_q.push_back(16'h99AA);
`ifdef LASER_TX_CHECKSUM_EN
    exp_q.push_back(16'hEE22);
`endif
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    send_byte(8'hAA);
    wait_idle();
    chk("restart_pulses", 16'(pulses), 16'(base + 1));
    chk("restart_count", pkt_count, 16'd1);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
